// File: rtl/piezo_alert_sched.sv
// Prioritising beep scheduler for the piezo tone path: arbitrates ovr_spd > batt_low > moving
// and gates the tone generator with each alert's own ON/OFF cadence, timed on a prescaled tick.
module piezo_alert_sched #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned OVR_ON   = 100,
    parameter int unsigned OVR_OFF  = 100,
    parameter int unsigned BATT_ON  = 200,
    parameter int unsigned BATT_OFF = 800,
    parameter int unsigned MOV_ON   = 100,
    parameter int unsigned MOV_OFF  = 1900
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       moving,
    input  logic       batt_low,
    input  logic       ovr_spd,
    output logic       tone_en,
    output logic [1:0] alert_id,
    output logic       busy,
    output logic       period_done
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [1:0] ID_NONE = 2'b00;
    localparam logic [1:0] ID_MOV  = 2'b01;
    localparam logic [1:0] ID_BATT = 2'b10;
    localparam logic [1:0] ID_OVR  = 2'b11;

    typedef enum logic [1:0] {StIdle, StBeepOn, StBeepOff} state_e;

    state_e           state_q;
    logic [2:0]       req_q;      // {ovr_spd, batt_low, moving}
    logic [PW-1:0]    presc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       cur_q;

    logic       tick;
    logic       preempt;
    logic       phase_end;
    logic [1:0] winner;

    function automatic logic [CNT_W-1:0] on_len(input logic [1:0] id);
        case (id)
            ID_OVR:  on_len = CNT_W'(OVR_ON);
            ID_BATT: on_len = CNT_W'(BATT_ON);
            default: on_len = CNT_W'(MOV_ON);
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] off_len(input logic [1:0] id);
        case (id)
            ID_OVR:  off_len = CNT_W'(OVR_OFF);
            ID_BATT: off_len = CNT_W'(BATT_OFF);
            default: off_len = CNT_W'(MOV_OFF);
        endcase
    endfunction

    always_comb begin
        winner = ID_NONE;
        if (req_q[2]) begin
            winner = ID_OVR;
        end else if (req_q[1]) begin
            winner = ID_BATT;
        end else if (req_q[0]) begin
            winner = ID_MOV;
        end
    end

    assign tick      = (presc_q == PRESC_MAX);
    assign preempt   = (state_q != StIdle) && req_q[2] && (cur_q != ID_OVR);
    assign phase_end = tick && (cnt_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            req_q       <= '0;
            presc_q     <= '0;
            cnt_q       <= '0;
            cur_q       <= ID_NONE;
            period_done <= 1'b0;
        end else begin
            req_q       <= {ovr_spd, batt_low, moving};
            period_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    presc_q <= '0;
                    if (|req_q) begin
                        state_q <= StBeepOn;
                        cur_q   <= winner;
                        cnt_q   <= on_len(winner);
                    end
                end
                StBeepOn, StBeepOff: begin
                    if (preempt) begin
                        // Over-speed aborts any lower beep at once; the aborted period
                        // never reports completion.
                        state_q <= StBeepOn;
                        cur_q   <= ID_OVR;
                        cnt_q   <= on_len(ID_OVR);
                        presc_q <= '0;
                    end else begin
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (phase_end) begin
                            if (state_q == StBeepOn) begin
                                state_q <= StBeepOff;
                                cnt_q   <= off_len(cur_q);
                            end else begin
                                period_done <= 1'b1;
                                if (|req_q) begin
                                    state_q <= StBeepOn;
                                    cur_q   <= winner;
                                    cnt_q   <= on_len(winner);
                                end else begin
                                    state_q <= StIdle;
                                    cur_q   <= ID_NONE;
                                end
                            end
                        end else if (tick) begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cur_q   <= ID_NONE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign tone_en  = (state_q == StBeepOn);
    assign busy     = (state_q != StIdle);
    assign alert_id = cur_q;

endmodule
